pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter: STALL_CNT_WIDTH, 16, width of the stall-cycle counter.
REQ-002 SHALL have port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port: id_valid_i  in  1  IF/ID holds a real instruction.
REQ-005 SHALL have ports: id_rs1_i, id_rs2_i  in  5 each  source registers of the ID instruction.
REQ-006 SHALL have ports: id_use_rs1_i, id_use_rs2_i  in  1 each  source actually read.
REQ-007 SHALL have ports: id_rd_i  in  5  destination register; id_reg_write_i  in  1  writes rd; id_mem_read_i  in  1  is a load.
REQ-008 SHALL have port: stall_o  out  1  hold PC and IF/ID this cycle.
REQ-009 SHALL have port: bubble_o  out  1  load all-zero control into ID/EX this cycle.
REQ-010 SHALL have ports: fwd_a_o, fwd_b_o  out  2 each  ALU operand source for the instruction in EX.
- 00 = ID/EX data; 01 = EX/MEM result; 10 = MEM/WB result; 11 = WB-held value.
REQ-011 SHALL have port: stall_count_o  out  STALL_CNT_WIDTH  saturating count of stalled cycles.

Function
REQ-012 SHALL track three in-flight entries: EX, MEM, WB. Each entry holds {valid, rd, reg_write, mem_read}.
REQ-013 Every cycle the entries SHALL shift: WB<=MEM, MEM<=EX, EX<=issued ID instruction, or an invalid entry when not issued.
REQ-014 Issue SHALL be id_valid_i && !stall_o.
REQ-015 A producer entry SHALL match a source when all of the following hold:
- valid && reg_write
- rd == source
- rd != 0
- the matching use bit is 1
REQ-016 Register x0 SHALL never cause a stall or a forward.
REQ-017 stall_o SHALL be combinational from the current entries and ID inputs; bubble_o SHALL equal stall_o.
REQ-018 stall_o SHALL be 0 whenever id_valid_i=0.
REQ-019 fwd_a_o/fwd_b_o SHALL be registered, computed at issue for the instruction entering EX, and be 00 when the EX entry is invalid.
- Priority at issue: EX match -> 01; else MEM match -> 10; else WB match -> 11; else 00.
REQ-020 When both sources match, stall SHALL be the OR of the two conditions, and each fwd SHALL be resolved independently.
REQ-021 stall_count_o SHALL increment by 1 every cycle stall_o=1, and hold at all-ones (no wrap).
REQ-022 A stalled instruction SHALL be re-evaluated each cycle; stall_o SHALL drop the first cycle no match condition remains.

Reset
REQ-023 On reset=1 at a clock edge, SHALL clear all three entries to invalid, clear fwd_a_o/fwd_b_o to 00, and clear stall_count_o to 0.
REQ-024 Reset SHALL override any concurrent issue or stall, including mid-stall.
REQ-025 In the first cycle after reset, stall_o SHALL depend only on ID inputs against empty entries (i.e. 0).

Configuration
REQ-026 Macro FORWARDING_EN SHALL select the forwarding behaviour.
REQ-027 With FORWARDING_EN defined:
- stall only on load-use, i.e. an EX entry with mem_read=1 matching a used source (1 stall cycle);
- fwd outputs per REQ-019.
REQ-028 Without FORWARDING_EN:
- stall while any EX, MEM or WB entry matches (up to 3 cycles);
- fwd_a_o/fwd_b_o SHALL be constant 00.

Verification
REQ-029 SHALL be covered: reset, then addi x5 issued, then add x6,x5,x5 in ID next cycle.
- FORWARDING_EN: stall_o=0, then fwd_a_o=fwd_b_o=01.
- Without: stall_o=1 for 3 cycles, stall_count_o=3.
REQ-030 SHALL be covered: lw x7 followed by add x8,x7,x1 (FORWARDING_EN).
- stall_o=bubble_o=1 for exactly 1 cycle.
- Then fwd_a_o=10, fwd_b_o=00.
REQ-031 SHALL be covered: addi x0,x0,1 followed by add x2,x0,x0 -> stall_o=0 and fwd=00 in both modes.
REQ-032 SHALL be covered: producer x9, two unrelated instructions, then a consumer of x9 (FORWARDING_EN) -> no stall, fwd_a_o=11.
REQ-033 SHALL be covered: assert reset during the 2nd cycle of a no-forwarding stall.
- Next cycle: stall_o=0, stall_count_o=0, all entries invalid.
REQ-034 SHALL be covered: preload stall_count_o to all-ones via 65535 stall cycles, then 1 more stall -> stall_count_o stays 16'hFFFF.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// ID-stage hazard bundle between the IF/ID register and the hazard controller.
// id_valid_i offers an instruction. It is issued into EX on a rising edge with id_valid_i=1 and stall_o=0.
// While stall_o=1 the ID fields must be held stable. Outputs flow back to the ID stage and the EX operand muxes.
interface pipeline_hazard_controller_if #(
    parameter int STALL_CNT_WIDTH = 16
);
    logic                       id_valid_i;
    logic [4:0]                 id_rs1_i;
    logic [4:0]                 id_rs2_i;
    logic                       id_use_rs1_i;
    logic                       id_use_rs2_i;
    logic [4:0]                 id_rd_i;
    logic                       id_reg_write_i;
    logic                       id_mem_read_i;

    logic                       stall_o;
    logic                       bubble_o;
    logic [1:0]                 fwd_a_o;
    logic [1:0]                 fwd_b_o;
    logic [STALL_CNT_WIDTH-1:0] stall_count_o;
    // {EX, MEM, WB} entries, each {valid, rd[4:0], reg_write, mem_read}
    logic [23:0]                dbg_entries_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_reg_write_i, id_mem_read_i,
        input  stall_o, bubble_o, fwd_a_o, fwd_b_o, stall_count_o, dbg_entries_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_reg_write_i, id_mem_read_i,
        output stall_o, bubble_o, fwd_a_o, fwd_b_o, stall_count_o, dbg_entries_o
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Data-hazard stall/bubble and operand-forwarding control for a 5-stage pipeline.
// Defining FORWARDING_EN enables forwarding and load-use-only stalls; otherwise it stalls until producers retire.
module pipeline_hazard_controller #(
    parameter int STALL_CNT_WIDTH = 16
) (
    input logic                         clk,
    input logic                         reset,
    pipeline_hazard_controller_if.slave hz
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } entry_t;

    localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = STALL_CNT_WIDTH'(1);
    localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = {STALL_CNT_WIDTH{1'b1}};

    entry_t                     ex_q, ex_d;
    entry_t                     mem_q, mem_d;
    entry_t                     wb_q, wb_d;
    logic [1:0]                 fwd_a_q, fwd_a_d;
    logic [1:0]                 fwd_b_q, fwd_b_d;
    logic [STALL_CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic hazard;
    logic stall;
    logic issue;

    // x0 is hardwired to zero, so it never produces a dependency
    function automatic logic src_match(input entry_t e, input logic [4:0] src,
                                       input logic use_src);
        return e.valid && e.reg_write && (e.rd == src) && (e.rd != 5'd0) && use_src;
    endfunction

`ifdef FORWARDING_EN
    function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem,
                                           input logic m_wb);
        logic [1:0] sel;
        sel = 2'b00;
        if (m_ex) begin
            sel = 2'b01;
        end else if (m_mem) begin
            sel = 2'b10;
        end else if (m_wb) begin
            sel = 2'b11;
        end
        return sel;
    endfunction
`endif

    assign ex_m1  = src_match(ex_q,  hz.id_rs1_i, hz.id_use_rs1_i);
    assign ex_m2  = src_match(ex_q,  hz.id_rs2_i, hz.id_use_rs2_i);
    assign mem_m1 = src_match(mem_q, hz.id_rs1_i, hz.id_use_rs1_i);
    assign mem_m2 = src_match(mem_q, hz.id_rs2_i, hz.id_use_rs2_i);
    assign wb_m1  = src_match(wb_q,  hz.id_rs1_i, hz.id_use_rs1_i);
    assign wb_m2  = src_match(wb_q,  hz.id_rs2_i, hz.id_use_rs2_i);

`ifdef FORWARDING_EN
    // Only a load still in EX has no value to forward yet
    assign hazard = ex_q.mem_read && (ex_m1 || ex_m2);
`else
    assign hazard = ex_m1 || ex_m2 || mem_m1 || mem_m2 || wb_m1 || wb_m2;
`endif

    assign stall = hz.id_valid_i && hazard;
    assign issue = hz.id_valid_i && !stall;

    always_comb begin
        ex_d    = '0;
        mem_d   = ex_q;
        wb_d    = mem_q;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        cnt_d   = cnt_q;

        if (issue) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = hz.id_rd_i;
            ex_d.reg_write = hz.id_reg_write_i;
            ex_d.mem_read  = hz.id_mem_read_i;
        end

`ifdef FORWARDING_EN
        // Producers shift one stage along with the consumer, so EX now means EX/MEM next cycle
        if (issue) begin
            fwd_a_d = fwd_sel(ex_m1, mem_m1, wb_m1);
            fwd_b_d = fwd_sel(ex_m2, mem_m2, wb_m2);
        end
`endif

        if (stall && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_o       = stall;
    assign hz.bubble_o      = stall;
    assign hz.fwd_a_o       = fwd_a_q;
    assign hz.fwd_b_o       = fwd_b_q;
    assign hz.stall_count_o = cnt_q;
    assign hz.dbg_entries_o = {ex_q, mem_q, wb_q};
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed-vector bench with an expected-response queue checked by an independent monitor.
// A second, 4-bit-counter instance sees the same stream to exercise counter saturation in few cycles.
module tb_pipeline_hazard_controller;
    localparam int W  = 16;
    localparam int SW = 4;
    localparam int EW = 1 + 1 + 2 + 2 + 3 + W + SW;

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } instr_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_controller_if #(.STALL_CNT_WIDTH(W))  hz();
    pipeline_hazard_controller_if #(.STALL_CNT_WIDTH(SW)) hs();

    pipeline_hazard_controller #(.STALL_CNT_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    pipeline_hazard_controller #(.STALL_CNT_WIDTH(SW)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .hz    (hs)
    );

    assign hs.id_valid_i     = hz.id_valid_i;
    assign hs.id_rs1_i       = hz.id_rs1_i;
    assign hs.id_rs2_i       = hz.id_rs2_i;
    assign hs.id_use_rs1_i   = hz.id_use_rs1_i;
    assign hs.id_use_rs2_i   = hz.id_use_rs2_i;
    assign hs.id_rd_i        = hz.id_rd_i;
    assign hs.id_reg_write_i = hz.id_reg_write_i;
    assign hs.id_mem_read_i  = hz.id_mem_read_i;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_q[$];
    string         nm_q[$];
    int            checks = 0;
    int            passed = 0;

    logic [2:0]    exp_dbg;
    logic [W-1:0]  exp_cnt;
    logic [SW-1:0] exp_cnt2;

    // ---------------- instruction builders ----------------
    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs1 = a; i.rs2 = b; i.u1 = 1'b1; i.u2 = 1'b1; i.rd = rd; i.rw = 1'b1;
        return i;
    endfunction

    // rs2 field carries a don't-care register that is not read
    function automatic instr_t imm(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] junk);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs1 = a; i.rs2 = junk; i.u1 = 1'b1; i.rd = rd; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t ld(input logic [4:0] rd, input logic [4:0] a);
        instr_t i;
        i = '0;
        i.v = 1'b1; i.rs1 = a; i.u1 = 1'b1; i.rd = rd; i.rw = 1'b1; i.mr = 1'b1;
        return i;
    endfunction

    // ---------------- driver ----------------
    // Drives one cycle of ID inputs and pushes the outputs expected in that cycle.
    // e_stall/e_fa/e_fb are hand-derived; entry valids and counters follow from them.
    task automatic step(input string nm, input instr_t in, input logic rst,
                        input logic e_stall, input logic [1:0] e_fa, input logic [1:0] e_fb);
        @(posedge clk);
        #1;
        reset             = rst;
        hz.id_valid_i     = in.v;
        hz.id_rs1_i       = in.rs1;
        hz.id_rs2_i       = in.rs2;
        hz.id_use_rs1_i   = in.u1;
        hz.id_use_rs2_i   = in.u2;
        hz.id_rd_i        = in.rd;
        hz.id_reg_write_i = in.rw;
        hz.id_mem_read_i  = in.mr;
        exp_q.push_back({e_stall, e_stall, e_fa, e_fb, exp_dbg, exp_cnt, exp_cnt2});
        nm_q.push_back(nm);
        if (rst) begin
            exp_dbg  = 3'b000;
            exp_cnt  = '0;
            exp_cnt2 = '0;
        end else begin
            exp_dbg = {in.v && !e_stall, exp_dbg[2:1]};
            if (e_stall) begin
                if (exp_cnt != {W{1'b1}}) exp_cnt++;
                if (exp_cnt2 != {SW{1'b1}}) exp_cnt2++;
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] act;
        string         nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = nm_q.pop_front();
            act = {hz.stall_o, hz.bubble_o, hz.fwd_a_o, hz.fwd_b_o,
                   hz.dbg_entries_o[23], hz.dbg_entries_o[15], hz.dbg_entries_o[7],
                   hz.stall_count_o, hs.stall_count_o};
            checks++;
            if (act !== e) begin
                $display("FAIL %s: got stall=%b bubble=%b fwd_a=%b fwd_b=%b vld=%b cnt=%h cnt4=%h, expected stall=%b bubble=%b fwd_a=%b fwd_b=%b vld=%b cnt=%h cnt4=%h",
                         nm, act[EW-1], act[EW-2], act[EW-3 -: 2], act[EW-5 -: 2], act[EW-7 -: 3],
                         act[SW +: W], act[SW-1:0],
                         e[EW-1], e[EW-2], e[EW-3 -: 2], e[EW-5 -: 2], e[EW-7 -: 3],
                         e[SW +: W], e[SW-1:0]);
            end else begin
                passed++;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_dbg  = 3'b000;
        exp_cnt  = '0;
        exp_cnt2 = '0;
        reset             = 1'b1;
        hz.id_valid_i     = 1'b0;
        hz.id_rs1_i       = 5'd0;
        hz.id_rs2_i       = 5'd0;
        hz.id_use_rs1_i   = 1'b0;
        hz.id_use_rs2_i   = 1'b0;
        hz.id_rd_i        = 5'd0;
        hz.id_reg_write_i = 1'b0;
        hz.id_mem_read_i  = 1'b0;
        @(posedge clk);

        step("reset_state", nop(), 1'b1, 1'b0, 2'b00, 2'b00);

`ifdef FORWARDING_EN
        step("r29_addi",  imm(5'd5, 5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r29_add",   alu(5'd6, 5'd5, 5'd5),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r29_fwd",   nop(),                        1'b0, 1'b0, 2'b01, 2'b01);
        step("r31_p",     imm(5'd0, 5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r31_c",     alu(5'd2, 5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r31_n",     nop(),                        1'b0, 1'b0, 2'b00, 2'b00);
        step("lu_lw",     ld(5'd7, 5'd1),               1'b0, 1'b0, 2'b00, 2'b00);
        step("lu_stall",  alu(5'd8, 5'd7, 5'd1),        1'b0, 1'b1, 2'b00, 2'b00);
        step("lu_go",     alu(5'd8, 5'd7, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00);
        step("lu_fwd",    nop(),                        1'b0, 1'b0, 2'b10, 2'b00);
        step("far_p",     imm(5'd9, 5'd3, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("far_u1",    imm(5'd10, 5'd3, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("far_u2",    imm(5'd11, 5'd3, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("far_c",     alu(5'd12, 5'd9, 5'd4),       1'b0, 1'b0, 2'b00, 2'b00);
        step("far_fwd",   nop(),                        1'b0, 1'b0, 2'b11, 2'b00);
        step("use_gate",  imm(5'd14, 5'd4, 5'd12),      1'b0, 1'b0, 2'b00, 2'b00);
        step("rs2_dep",   alu(5'd15, 5'd4, 5'd12),      1'b0, 1'b0, 2'b00, 2'b00);
        step("invalid",   '{v:1'b0, rs1:5'd15, rs2:5'd15, u1:1'b1, u2:1'b1, rd:5'd1, rw:1'b1, mr:1'b0},
                                                        1'b0, 1'b0, 2'b00, 2'b11);
        step("pr_1",      imm(5'd21, 5'd4, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("pr_2",      imm(5'd21, 5'd4, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("pr_c",      alu(5'd22, 5'd21, 5'd21),     1'b0, 1'b0, 2'b00, 2'b00);
        step("pr_fwd",    nop(),                        1'b0, 1'b0, 2'b01, 2'b01);
        step("r33_p",     ld(5'd16, 5'd4),              1'b0, 1'b0, 2'b00, 2'b00);
        step("r33_rst",   alu(5'd17, 5'd16, 5'd16),     1'b1, 1'b1, 2'b00, 2'b00);
        step("r33_after", alu(5'd17, 5'd16, 5'd16),     1'b0, 1'b0, 2'b00, 2'b00);
        step("r33_n",     nop(),                        1'b0, 1'b0, 2'b00, 2'b00);
        // Back-to-back dependent loads: one stall each, then MEM forwarding
        for (int k = 0; k < 20; k++) begin
            if (k > 0) begin
                step("sat_stall", ld(5'd20, 5'd20), 1'b0, 1'b1, (k >= 2) ? 2'b10 : 2'b00, 2'b00);
            end
            step("sat_issue", ld(5'd20, 5'd20), 1'b0, 1'b0, 2'b00, 2'b00);
        end
        step("tail",      nop(),                        1'b0, 1'b0, 2'b10, 2'b00);
`else
        step("r29_addi",  imm(5'd5, 5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r29_s1",    alu(5'd6, 5'd5, 5'd5),        1'b0, 1'b1, 2'b00, 2'b00);
        step("r29_s2",    alu(5'd6, 5'd5, 5'd5),        1'b0, 1'b1, 2'b00, 2'b00);
        step("r29_s3",    alu(5'd6, 5'd5, 5'd5),        1'b0, 1'b1, 2'b00, 2'b00);
        step("r29_go",    alu(5'd6, 5'd5, 5'd5),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r31_p",     imm(5'd0, 5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r31_c",     alu(5'd2, 5'd0, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("r31_n",     nop(),                        1'b0, 1'b0, 2'b00, 2'b00);
        step("lu_lw",     ld(5'd7, 5'd1),               1'b0, 1'b0, 2'b00, 2'b00);
        step("lu_s1",     alu(5'd8, 5'd7, 5'd1),        1'b0, 1'b1, 2'b00, 2'b00);
        step("lu_s2",     alu(5'd8, 5'd7, 5'd1),        1'b0, 1'b1, 2'b00, 2'b00);
        step("lu_s3",     alu(5'd8, 5'd7, 5'd1),        1'b0, 1'b1, 2'b00, 2'b00);
        step("lu_go",     alu(5'd8, 5'd7, 5'd1),        1'b0, 1'b0, 2'b00, 2'b00);
        step("far_p",     imm(5'd9, 5'd3, 5'd0),        1'b0, 1'b0, 2'b00, 2'b00);
        step("far_u1",    imm(5'd10, 5'd3, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("far_u2",    imm(5'd11, 5'd3, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("far_wb",    alu(5'd12, 5'd9, 5'd4),       1'b0, 1'b1, 2'b00, 2'b00);
        step("far_go",    alu(5'd12, 5'd9, 5'd4),       1'b0, 1'b0, 2'b00, 2'b00);
        step("use_gate",  imm(5'd14, 5'd4, 5'd12),      1'b0, 1'b0, 2'b00, 2'b00);
        step("rs2_mem",   alu(5'd15, 5'd4, 5'd12),      1'b0, 1'b1, 2'b00, 2'b00);
        step("rs2_wb",    alu(5'd15, 5'd4, 5'd12),      1'b0, 1'b1, 2'b00, 2'b00);
        step("rs2_go",    alu(5'd15, 5'd4, 5'd12),      1'b0, 1'b0, 2'b00, 2'b00);
        step("invalid",   '{v:1'b0, rs1:5'd15, rs2:5'd15, u1:1'b1, u2:1'b1, rd:5'd1, rw:1'b1, mr:1'b0},
                                                        1'b0, 1'b0, 2'b00, 2'b00);
        step("r33_p",     imm(5'd16, 5'd4, 5'd0),       1'b0, 1'b0, 2'b00, 2'b00);
        step("r33_s1",    alu(5'd17, 5'd16, 5'd16),     1'b0, 1'b1, 2'b00, 2'b00);
        step("r33_rst",   alu(5'd17, 5'd16, 5'd16),     1'b1, 1'b1, 2'b00, 2'b00);
        step("r33_after", alu(5'd17, 5'd16, 5'd16),     1'b0, 1'b0, 2'b00, 2'b00);
        // Dependent chain: each consumer waits three cycles for its producer to retire
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                for (int s = 0; s < 3; s++) begin
                    step("sat_stall", alu(5'd20, 5'd20, 5'd20), 1'b0, 1'b1, 2'b00, 2'b00);
                end
            end
            step("sat_issue", alu(5'd20, 5'd20, 5'd20), 1'b0, 1'b0, 2'b00, 2'b00);
        end
        step("tail",      nop(),                        1'b0, 1'b0, 2'b00, 2'b00);
`endif

        step("tail_hold", nop(),                        1'b0, 1'b0, 2'b00, 2'b00);
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
